// File: rtl/mmio_pkg.sv
// Shared constants and types for the data-side memory subsystem.
package mmio_pkg;

  // Address map
  localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
  localparam logic [31:0] OFF_TIMER_COUNT = 32'h0000_0000;
  localparam logic [31:0] OFF_TIMER_CMP   = 32'h0000_0004;
  localparam logic [31:0] OFF_TIMER_STAT  = 32'h0000_0008;
  localparam logic [31:0] OFF_UART_DATA   = 32'h0000_0010;
  localparam logic [31:0] OFF_UART_STAT   = 32'h0000_0014;

  localparam logic [31:0] ADDR_TIMER_COUNT = MMIO_BASE + OFF_TIMER_COUNT;
  localparam logic [31:0] ADDR_TIMER_CMP   = MMIO_BASE + OFF_TIMER_CMP;
  localparam logic [31:0] ADDR_TIMER_STAT  = MMIO_BASE + OFF_TIMER_STAT;
  localparam logic [31:0] ADDR_UART_DATA   = MMIO_BASE + OFF_UART_DATA;
  localparam logic [31:0] ADDR_UART_STAT   = MMIO_BASE + OFF_UART_STAT;

  // UART serializer states
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // UART_STAT bit positions
  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;

endpackage

// File: rtl/mmio_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BaudOne  = BW'(1);
  localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        ovf_q;
  logic        pop, push_ok;

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A same-edge pop frees a slot, so a push into a full FIFO is accepted then.
  assign push_ok = push && (!full || pop);

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop)     rptr_q <= rptr_q + PtrOne;
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (clr_ovf)     ovf_q <= 1'b0;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr_q[AW-1:0]] <= push_data;
  end

  // Serializer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Serializer next-state logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rptr_q[AW-1:0]];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      StData: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the next state, registered so uart_tx comes straight from a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign overflow = ovf_q;
  assign uart_tx  = tx_q;

endmodule

// File: rtl/data_bus_mmio.sv
// Data-side memory: word RAM, free-running timer with compare flag, and UART TX window.
module data_bus_mmio
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int unsigned RIW = $clog2(RAM_WORDS);

  logic [31:0]    ram_q [RAM_WORDS];
  logic [RIW-1:0] ram_idx;
  logic [31:0]    word_addr;
  logic           unused_addr;
  logic           sel_ram;
  logic           wr_cmp, wr_stat, push, clr_ovf;
  logic [31:0]    count_q, cmp_q;
  logic           match_q;
  logic           u_empty, u_full, u_busy, u_ovf;
  logic [31:0]    uart_stat;

  // Word accesses only: byte offset bits are dropped from the decode.
  assign word_addr   = {Addr[31:2], 2'b00};
  assign unused_addr = ^Addr[1:0];
  assign ram_idx     = Addr[RIW+1:2];
  assign sel_ram     = !Addr[31];

  assign wr_cmp  = MemWrite && (word_addr == ADDR_TIMER_CMP);
  assign wr_stat = MemWrite && (word_addr == ADDR_TIMER_STAT);
  assign push    = MemWrite && (word_addr == ADDR_UART_DATA);
  assign clr_ovf = MemWrite && (word_addr == ADDR_UART_STAT) && WriteData[3];

  // Word RAM, contents survive reset
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) ram_q[ram_idx] <= WriteData;
  end

  // Timer: free-running count, compare register, sticky match (set beats W1C)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
    end else begin
      count_q <= count_q + 32'd1;
      if (wr_cmp) cmp_q <= WriteData;
      if (count_q == cmp_q)               match_q <= 1'b1;
      else if (wr_stat && WriteData[0])   match_q <= 1'b0;
    end
  end

  assign timer_irq = match_q;

  mmio_uart_tx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(WriteData[7:0]),
    .clr_ovf  (clr_ovf),
    .empty    (u_empty),
    .full     (u_full),
    .busy     (u_busy),
    .overflow (u_ovf),
    .uart_tx  (uart_tx)
  );

  // Assemble UART status word
  always_comb begin
    uart_stat                 = '0;
    uart_stat[STAT_EMPTY_BIT] = u_empty;
    uart_stat[STAT_FULL_BIT]  = u_full;
    uart_stat[STAT_BUSY_BIT]  = u_busy;
    uart_stat[STAT_OVF_BIT]   = u_ovf;
  end

  // Combinational read mux
  always_comb begin
    ReadData = '0;
    if (sel_ram) begin
      ReadData = ram_q[ram_idx];
    end else begin
      case (word_addr)
        ADDR_TIMER_COUNT: ReadData = count_q;
        ADDR_TIMER_CMP:   ReadData = cmp_q;
        ADDR_TIMER_STAT:  ReadData = {31'd0, match_q};
        ADDR_UART_STAT:   ReadData = uart_stat;
        default:          ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_mmio.sv
// Self-checking bench for data_bus_mmio: vector table, directed corner sequences,
// randomized RAM traffic and a line-level UART receiver.
module tb_data_bus_mmio;

  localparam logic [31:0] A_CNT   = 32'h8000_0000;
  localparam logic [31:0] A_CMP   = 32'h8000_0004;
  localparam logic [31:0] A_TSTAT = 32'h8000_0008;
  localparam logic [31:0] A_UDATA = 32'h8000_0010;
  localparam logic [31:0] A_USTAT = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected timer value: cycles elapsed since reset released
  logic [31:0] cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  data_bus_mmio #(
    .RAM_WORDS   (64),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .uart_tx  (uart_tx),
    .timer_irq(timer_irq)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [31:0] d, tgt;
  logic [9:0]  frame;
  logic [7:0]  bytes [6];
  logic [7:0]  got;
  logic        ok, found, saw_low;
  logic [31:0] model [64];
  logic        valid [64];
  logic [31:0] r, a, wv;
  logic [5:0]  idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Combinational load, called just after a falling edge
  task automatic rd(input logic [31:0] ad, output logic [31:0] dv);
    Addr = ad;
    #1;
    dv = ReadData;
  endtask

  // Store that commits on the next rising edge; returns on the following falling edge
  task automatic wr(input logic [31:0] ad, input logic [31:0] dv);
    MemWrite  = 1'b1;
    Addr      = ad;
    WriteData = dv;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  // Line-level 8N1 receiver sampling mid-bit, 4 clocks per bit
  task automatic rx_byte(output logic [7:0] b, output logic okv);
    int n;
    n   = 0;
    b   = '0;
    okv = 1'b0;
    while (uart_tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (2) @(negedge clk);
    if (uart_tx !== 1'b0) return;
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk);
      b[k] = uart_tx;
    end
    repeat (4) @(negedge clk);
    okv = (uart_tx === 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0110, 32'hCAFE_F00D};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 32'h8000_0020, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h8000_0020, 32'h1234_5678};
    vecs[8]  = '{1'b0, 32'h8000_0020, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0BAD_F00D};
    vecs[10] = '{1'b1, 32'h8000_0004, 32'hFFFF_0000};
    vecs[11] = '{1'b0, 32'h8000_0007, 32'hFFFF_0000};
    vecs[12] = '{1'b0, 32'h8000_0010, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'h8000_0014, 32'h0000_0001};
    vecs[14] = '{1'b0, 32'h8000_0008, 32'h0000_0000};
    vecs[15] = '{1'b0, 32'h8000_000C, 32'h0000_0000};
    vecs[16] = '{1'b1, 32'h8000_0000, 32'h5555_5555};
    vecs[17] = '{1'b1, 32'h0000_0FFC, 32'h1111_1111};
    vecs[18] = '{1'b0, 32'h0000_00FC, 32'h1111_1111};
    vecs[19] = '{1'b0, 32'h7FFF_FFFC, 32'h1111_1111};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_irq", timer_irq, 0);
    rd(A_CNT, d);   check("rst_count", d, 0);
    rd(A_CMP, d);   check("rst_cmp", d, 32'hFFFF_FFFF);
    rd(A_TSTAT, d); check("rst_tstat", d, 0);
    rd(A_USTAT, d); check("rst_ustat", d, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Timer compare, sticky flag, W1C
    repeat (4) @(negedge clk);
    wr(A_CMP, 32'd20);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(A_CNT, d);
      if (d == 32'd20) found = 1'b1;
      else @(negedge clk);
    end
    check("tmr_reach20", {31'd0, found}, 1);
    check("tmr_count_model", d, cyc);
    check("tmr_irq_before", timer_irq, 0);
    @(negedge clk);
    check("tmr_irq_rise", timer_irq, 1);
    repeat (5) @(negedge clk);
    check("tmr_irq_hold", timer_irq, 1);
    rd(A_TSTAT, d); check("tmr_stat_set", d, 1);
    wr(A_TSTAT, 32'h0);
    check("tmr_w0_keeps", timer_irq, 1);
    wr(A_TSTAT, 32'h1);
    check("tmr_w1c_irq", timer_irq, 0);
    rd(A_TSTAT, d); check("tmr_w1c_stat", d, 0);
    @(negedge clk);

    // Vector table: RAM aliasing and MMIO decode
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, d);
        check($sformatf("vec%0d_rd_%08h", i, vecs[i].addr), d, vecs[i].data);
        @(negedge clk);
      end
    end
    rd(A_CNT, d); check("count_ro", d, cyc);
    @(negedge clk);

    // Set beats a W1C on the same edge
    rd(A_CNT, d);
    tgt = d + 32'd8;
    wr(A_CMP, tgt);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      rd(A_CNT, d);
      if (d == tgt) begin
        found = 1'b1;
        check("sw_irq_pre", timer_irq, 0);
        MemWrite  = 1'b1;
        Addr      = A_TSTAT;
        WriteData = 32'h1;
        @(negedge clk);
        MemWrite  = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("sw_reach", {31'd0, found}, 1);
    check("sw_irq_set_wins", timer_irq, 1);
    rd(A_TSTAT, d); check("sw_stat", d, 1);
    @(negedge clk);

    // Single UART frame, 0xA5, sampled every cycle
    frame = {1'b1, 8'hA5, 1'b0};
    wr(A_UDATA, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("frame_tx_%0d", i), uart_tx, frame[i/4]);
      rd(A_USTAT, d);
      check($sformatf("frame_busy_%0d", i), {31'd0, d[2]}, 1);
    end
    @(negedge clk);
    check("frame_idle_tx", uart_tx, 1);
    rd(A_USTAT, d); check("frame_idle_stat", d, 32'h1);

    // FIFO full / overflow while the serializer is busy
    for (int k = 0; k < 6; k++) bytes[k] = 8'($urandom_range(0, 255));
    fork
      begin
        wr(A_UDATA, {24'd0, bytes[0]});
        repeat (2) @(negedge clk);
        for (int k = 1; k < 6; k++) wr(A_UDATA, {24'd0, bytes[k]});
        rd(A_USTAT, d); check("ovf_stat_full", d, 32'hE);
        wr(A_USTAT, 32'h8);
        rd(A_USTAT, d); check("ovf_stat_clr", d, 32'h6);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx_byte(got, ok);
          check($sformatf("ovf_rx_ok_%0d", k), {31'd0, ok}, 1);
          check($sformatf("ovf_rx_byte_%0d", k), {24'd0, got}, {24'd0, bytes[k]});
        end
      end
    join
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("ovf_dropped_not_sent", {31'd0, saw_low}, 0);
    rd(A_USTAT, d); check("ovf_drained", d, 32'h1);
    @(negedge clk);

    // Randomized RAM traffic against an array model, random upper alias bits
    for (int i = 0; i < 64; i++) valid[i] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r   = $urandom();
      idx = 6'($urandom_range(0, 7));
      a   = {1'b0, r[30:8], idx, r[1:0]};
      if ($urandom_range(0, 1) == 1 || !valid[idx]) begin
        wv = $urandom();
        wr(a, wv);
        model[idx] = wv;
        valid[idx] = 1'b1;
      end else begin
        rd(a, d);
        check($sformatf("rnd_ram_%08h", a), d, model[idx]);
        @(negedge clk);
      end
    end

    // Randomized short UART burst
    for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom_range(0, 255));
    fork
      begin
        for (int k = 0; k < 3; k++) wr(A_UDATA, {24'd0, bytes[k]});
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_byte(got, ok);
          check($sformatf("rnd_rx_ok_%0d", k), {31'd0, ok}, 1);
          check($sformatf("rnd_rx_byte_%0d", k), {24'd0, got}, {24'd0, bytes[k]});
        end
      end
    join
    repeat (4) @(negedge clk);
    rd(A_USTAT, d); check("rnd_uart_idle", d, 32'h1);
    @(negedge clk);

    // Asynchronous reset during data bit 3 with a byte still queued
    check("ar_irq_pre", timer_irq, 1);
    wr(A_UDATA, 32'h00);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check("ar_start_seen", {31'd0, found}, 1);
    wr(A_UDATA, 32'h00);
    repeat (16) @(negedge clk);
    check("ar_tx_pre", uart_tx, 0);
    Addr = A_CNT;
    #2;
    reset = 1'b1;
    #1;
    check("ar_tx_async", uart_tx, 1);
    check("ar_irq_async", timer_irq, 0);
    check("ar_count_async", ReadData, 0);
    @(negedge clk);
    reset = 1'b0;
    rd(A_USTAT, d); check("ar_ustat_after", d, 32'h1);
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("ar_no_frame_after", {31'd0, saw_low}, 0);
    rd(A_CNT, d); check("ar_count_model", d, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_mmio.md
Name: data_bus_mmio

Overview:
Data-side memory subsystem sitting directly downstream of the single-cycle core: it consumes MemWrite, address (ALUResult) and WriteData and returns ReadData in the same cycle. It decodes the address into word RAM plus a small MMIO window. The window holds a free-running timer with compare flag and a buffered 8N1 UART transmitter.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words (power of 2)
FIFO_DEPTH, 4, UART TX byte FIFO depth (power of 2, >=2)
CLKS_PER_BIT, 4, clk cycles per UART bit (>=2)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  store strobe from core
Addr  input  32  byte address (core ALUResult)
WriteData  input  32  store data
ReadData  output  32  load data, combinational from Addr
uart_tx  output  1  serial line, idle high
timer_irq  output  1  level copy of the timer match flag

Behaviour:
- One clock. Reset is asynchronous and active-high. All writes commit on the rising clk edge when MemWrite=1. Reads are combinational, with zero-cycle latency as the single-cycle core requires.
- Word accesses only. Addr[1:0] is ignored.
- Address map:
  - Addr[31]=0: RAM, index Addr[log2(RAM_WORDS)+1:2], aliased.
  - 0x8000_0000 TIMER_COUNT (RO).
  - 0x8000_0004 TIMER_CMP (RW).
  - 0x8000_0008 TIMER_STAT (bit0 match, W1C).
  - 0x8000_0010 UART_DATA (W: push WriteData[7:0]; R: 0).
  - 0x8000_0014 UART_STAT (R: bit0 empty, bit1 full, bit2 busy, bit3 overflow; W: bit3=1 clears overflow).
  - Any other Addr[31]=1 address: reads return 0, writes are ignored.
- Reset values:
  - TIMER_COUNT=0, TIMER_CMP=0xFFFF_FFFF, match=0.
  - FIFO empty, overflow=0, UART FSM IDLE.
  - uart_tx=1, timer_irq=0.
  - ReadData reflects the reset state combinationally.
  - RAM contents are not cleared.
- Reset mid-operation: uart_tx returns to 1 immediately (asynchronous), the in-flight frame is lost, and the FIFO is emptied.
- Timer:
  - TIMER_COUNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. Writes to it are ignored.
  - When count == CMP, match is set on the next edge.
  - If a W1C write and a match occur on the same edge, set wins.
  - A write to TIMER_CMP takes effect for the comparison from the next cycle.
- UART FIFO:
  - Pointers carry an extra wrap bit. Full means FIFO_DEPTH bytes are stored.
  - A push while full drops the byte and sets overflow (sticky).
  - A push and a pop on the same edge are both honoured, including when full: the pop frees the slot first. Count is unchanged.
- UART FSM (states IDLE, START, DATA, STOP; baud counter 0..CLKS_PER_BIT-1; bit index 0..7):
  - IDLE: if FIFO not empty, pop into the shift register and go to START. uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE. Back-to-back frames add one IDLE cycle.
  - busy = (state != IDLE).
- uart_tx and timer_irq are driven from flops, with no combinational path from the inputs.

Decomposition:
- Shared package mmio_pkg holds:
  - address constants (MMIO_BASE and the register offsets);
  - the UART state enum type (IDLE/START/DATA/STOP);
  - the UART_STAT bit-position constants.
- One sub-module, mmio_uart_tx: FIFO plus serializer FSM.
  - Parameters FIFO_DEPTH and CLKS_PER_BIT.
  - Ports: push, push_data[7:0], clr_ovf, empty, full, busy, overflow, uart_tx.
- The top holds RAM, timer, address decode and the read mux.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010, then 0xCAFEF00D to 0x0000_0110 (aliases index 4 for 64 words) -> read 0x10 returns 0xCAFEF00D. Read 0x13 returns the same word.
- Timer: release reset, write CMP=20 at cycle 5 -> timer_irq rises on the edge after count==20 and stays high. A W1C write of 1 to 0x8000_0008 clears it. Unmapped 0x8000_0020 reads 0.
- Timer set-wins: issue a W1C write on the exact edge where count==CMP -> match remains 1.
- UART frame: push 0xA5 with CLKS_PER_BIT=4 -> uart_tx sequence is 0 (start), 1,0,1,0,0,1,0,1, then 1 (stop), each 4 cycles. busy=1 throughout, then empty=1 and busy=0.
- FIFO full/overflow:
  - Push 5 bytes back-to-back while the FSM is busy -> full=1 and overflow=1 after the 5th push. Dropped byte is never transmitted; the other 4 go out in order.
  - Writing 0x8 to UART_STAT clears overflow.
- Async reset mid-frame: assert reset during DATA bit 3 (between clock edges) -> uart_tx=1, timer_irq=0 and TIMER_COUNT reads 0 before the next edge. After release, FIFO is empty and idle.
